// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over req/gnt/rvalid and holds one instruction for decode.
// Optional build macro MISALIGN_CHECK_EN adds fetch_misaligned and an ERR state for unaligned targets.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] ImmExt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef MISALIGN_CHECK_EN
    ,
    output logic        fetch_misaligned
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
`ifdef MISALIGN_CHECK_EN
        ,
        S_ERR
`endif
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_instr_valid;
    logic        r_misaligned;

    state_t      w_state_d;
    logic [31:0] w_pc_d;
    logic [31:0] w_instr_d;
    logic [31:0] w_instr_pc_d;
    logic        w_instr_valid_d;
    logic        w_misaligned_d;

    logic        w_consume;
    logic        w_take_tgt;
    logic [31:0] w_raw_tgt;
    logic [31:0] w_tgt;

    assign w_consume = r_instr_valid & instr_ready;
    assign w_raw_tgt = redirect_valid ? redirect_pc : (r_instr_pc + ImmExt);
    assign w_tgt     = w_raw_tgt & ~32'h3;
    // A redirect outranks a branch; neither can fire before the first request.
    assign w_take_tgt = ((r_state != S_IDLE) && redirect_valid) ||
                        ((r_state == S_HOLD) && w_consume && branch_taken);

    always_comb begin
        w_state_d       = r_state;
        w_pc_d          = r_pc;
        w_instr_d       = r_instr;
        w_instr_pc_d    = r_instr_pc;
        w_instr_valid_d = r_instr_valid;
        w_misaligned_d  = r_misaligned;
        imem_req        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_d = S_REQ;
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    // A grant in the redirect cycle still owes a response that must be drained.
                    w_state_d = imem_gnt ? S_DRAIN : S_REQ;
                end else if (imem_gnt) begin
                    w_state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_state_d = imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem_rvalid) begin
                    w_instr_d       = imem_rdata;
                    w_instr_pc_d    = r_pc;
                    w_instr_valid_d = 1'b1;
                    w_pc_d          = r_pc + 32'd4;
                    w_state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid || w_consume) begin
                    w_instr_valid_d = 1'b0;
                    w_instr_d       = NOP_INSTR;
                    w_state_d       = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    w_state_d = S_REQ;
                end
            end
`ifdef MISALIGN_CHECK_EN
            S_ERR: begin
                if (redirect_valid && (w_raw_tgt[1:0] == 2'b00)) begin
                    w_state_d = S_REQ;
                end
            end
`endif
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        if (w_take_tgt) begin
            if (redirect_valid) begin
                w_instr_valid_d = 1'b0;
                w_instr_d       = NOP_INSTR;
            end
`ifdef MISALIGN_CHECK_EN
            if (w_raw_tgt[1:0] != 2'b00) begin
                w_misaligned_d  = 1'b1;
                w_instr_valid_d = 1'b0;
                w_instr_d       = NOP_INSTR;
                w_state_d       = S_ERR;
            end else begin
                w_misaligned_d  = 1'b0;
                w_pc_d          = w_raw_tgt;
            end
`else
            w_pc_d = w_tgt;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_pc          <= w_pc_d;
            r_instr       <= w_instr_d;
            r_instr_pc    <= w_instr_pc_d;
            r_instr_valid <= w_instr_valid_d;
            r_misaligned  <= w_misaligned_d;
        end
    end

    assign imem_addr   = r_pc;
    assign Instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
`ifdef MISALIGN_CHECK_EN
    assign fetch_misaligned = r_misaligned;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level fetch model, memory responder and directed scenarios.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] Instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] ImmExt = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef MISALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .Instr(Instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .branch_taken(branch_taken), .ImmExt(ImmExt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef MISALIGN_CHECK_EN
        , .fetch_misaligned(fetch_misaligned)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit seen_dead = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Instruction memory contents: one poisoned word at 0x20, otherwise derived from the address.
    function automatic logic [31:0] dfun(input logic [31:0] a);
        if (a == 32'h20) return 32'hDEADBEEF;
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory responder: answers every grant in order, rv_delay cycles after the grant cycle.
    int          rv_delay = 1;
    int          cyc = 0;
    logic [31:0] rq_addr[$];
    int          rq_due[$];

    always @(posedge clk) begin
        if (imem_rvalid && rq_addr.size() > 0) begin
            void'(rq_addr.pop_front());
            void'(rq_due.pop_front());
        end
        if (imem_req && imem_gnt) begin
            rq_addr.push_back(imem_addr);
            rq_due.push_back(cyc + rv_delay);
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (rq_addr.size() > 0 && rq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = dfun(rq_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    // Fetch model: one outstanding fetch or one held instruction at a time; redirects kill in-flight data.
    bit          m_started, m_valid, m_out, m_live, m_err;
    logic [31:0] m_pc, m_instr, m_ipc, m_faddr;
    bit          md_req, md_deliver, md_cons;

    task automatic set_target(input logic [31:0] t);
`ifdef MISALIGN_CHECK_EN
        if (t[1:0] != 2'b00) begin
            m_err   = 1'b1;
            m_valid = 1'b0;
            m_instr = NOP;
        end else begin
            m_err = 1'b0;
            m_pc  = t;
        end
`else
        m_pc = t & ~32'h3;
`endif
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started = 1'b0; m_valid = 1'b0; m_out = 1'b0; m_live = 1'b0; m_err = 1'b0;
            m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0; m_faddr = 32'h0;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else begin
            md_req     = m_started && !m_valid && !m_out && !m_err;
            md_deliver = m_out && imem_rvalid;
            md_cons    = m_valid && instr_ready;
            if (md_deliver) m_out = 1'b0;
            if (redirect_valid) begin
                m_valid = 1'b0;
                m_instr = NOP;
                m_live  = 1'b0;
                if (md_req && imem_gnt) m_out = 1'b1;
                set_target(redirect_pc);
            end else begin
                if (md_deliver && m_live) begin
                    m_valid = 1'b1;
                    m_instr = imem_rdata;
                    m_ipc   = m_faddr;
                end
                if (md_req && imem_gnt) begin
                    m_out   = 1'b1;
                    m_live  = 1'b1;
                    m_faddr = m_pc;
                    m_pc    = m_pc + 32'd4;
                end
                if (md_cons) begin
                    m_valid = 1'b0;
                    m_instr = NOP;
                    if (branch_taken) set_target(m_ipc + ImmExt);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_valid", instr_valid, m_valid);
            chk("m_instr", Instr, m_valid ? m_instr : NOP);
            if (m_valid) chk("m_ipc", instr_pc, m_ipc);
            chk("m_req", imem_req, m_started && !m_valid && !m_out && !m_err);
            if (m_started && !m_valid && !m_out && !m_err) chk("m_addr", imem_addr, m_pc);
`ifdef MISALIGN_CHECK_EN
            chk("m_misaligned", fetch_misaligned, m_err);
`endif
            if (instr_valid && Instr == 32'hDEADBEEF) seen_dead = 1'b1;
        end
    end

    task automatic do_redirect(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) begin
            checks++;
            errors++;
            $display("FAIL %s timeout instr_valid=0 expected=1", name);
        end
    endtask

    task automatic wait_next_grant(input string name, input logic [31:0] exp);
        int n = 0;
        while (!(imem_req && imem_gnt) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!(imem_req && imem_gnt)) begin
            checks++;
            errors++;
            $display("FAIL %s timeout no grant, expected addr=%h", name, exp);
        end else begin
            chk(name, imem_addr, exp);
        end
    endtask

    logic [31:0] ga[$];
    logic [31:0] vi[$];
    int          gc[$];
    int          vc[$];

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", Instr, NOP);
        chk("rst_ipc", instr_pc, 32'h0);
        chk("rst_valid", instr_valid, 1'b0);

        // Streaming from reset: gnt tied high, response one cycle after grant.
        imem_gnt = 1'b1;
        instr_ready = 1'b1;
        rst_n = 1'b1;
        for (int t = 0; t < 12; t++) begin
            if (imem_req && imem_gnt) begin ga.push_back(imem_addr); gc.push_back(t); end
            if (instr_valid) begin vc.push_back(t); vi.push_back(Instr); end
            @(negedge clk);
        end
        chk("t1_ngrant", ga.size() >= 3, 1'b1);
        chk("t1_nvalid", vc.size() >= 3, 1'b1);
        if (ga.size() >= 3 && vc.size() >= 3) begin
            chk("t1_addr0", ga[0], 32'h0);
            chk("t1_addr1", ga[1], 32'h4);
            chk("t1_addr2", ga[2], 32'h8);
            chk("t1_gnt_cycle", gc[0], 1);
            chk("t1_latency", vc[0], 3);
            chk("t1_period0", vc[1] - vc[0], 3);
            chk("t1_period1", vc[2] - vc[1], 3);
            chk("t1_instr0", vi[0], 32'hFFFF_0000);
            chk("t1_instr1", vi[1], 32'hFFFB_0004);
        end

        // Stall in HOLD for five cycles.
        instr_ready = 1'b0;
        do_redirect(32'h40);
        wait_valid("t2_wait");
        chk("t2_instr", Instr, 32'hFFBF_0040);
        chk("t2_ipc", instr_pc, 32'h40);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_instr", Instr, 32'hFFBF_0040);
            chk("t2_hold_ipc", instr_pc, 32'h40);
            chk("t2_hold_valid", instr_valid, 1'b1);
            chk("t2_hold_req", imem_req, 1'b0);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        wait_next_grant("t2_next_addr", 32'h44);

        // Backward branch: 0x100 + 0xFFFF_FFF0.
        do_redirect(32'h100);
        wait_valid("t3_wait");
        chk("t3_ipc", instr_pc, 32'h100);
        branch_taken = 1'b1; ImmExt = 32'hFFFF_FFF0; instr_ready = 1'b1;
        @(negedge clk);
        branch_taken = 1'b0; ImmExt = 32'h0; instr_ready = 1'b0;
        wait_next_grant("t3_branch_addr", 32'h0F0);

        // Redirect while waiting on memory; the late 0xDEADBEEF response must be dropped.
        rv_delay = 3;
        instr_ready = 1'b1;
        do_redirect(32'h20);
        wait_next_grant("t4_gnt20", 32'h20);
        @(negedge clk);
        do_redirect(32'h400);
        chk("t4_drain_req0", imem_req, 1'b0);
        @(negedge clk);
        chk("t4_drain_req1", imem_req, 1'b0);
        rv_delay = 1;
        @(negedge clk);
        chk("t4_req", imem_req, 1'b1);
        chk("t4_addr", imem_addr, 32'h400);
        instr_ready = 1'b0;
        wait_valid("t4_wait");
        chk("t4_instr", Instr, 32'hFBFF_0400);
        chk("t4_ipc", instr_pc, 32'h400);

        // Redirect and taken branch on the same consume cycle.
        do_redirect(32'h300);
        wait_valid("t5_wait");
        chk("t5_ipc", instr_pc, 32'h300);
        instr_ready = 1'b1; branch_taken = 1'b1; ImmExt = 32'hFFFF_FF00;
        redirect_valid = 1'b1; redirect_pc = 32'h800;
        @(negedge clk);
        instr_ready = 1'b0; branch_taken = 1'b0; ImmExt = 32'h0; redirect_valid = 1'b0;
        wait_next_grant("t5_redirect_wins", 32'h800);

        // Unaligned branch target 0x102.
        do_redirect(32'h100);
        wait_valid("t6_wait");
        instr_ready = 1'b1; branch_taken = 1'b1; ImmExt = 32'h2;
        @(negedge clk);
        instr_ready = 1'b0; branch_taken = 1'b0; ImmExt = 32'h0;
`ifdef MISALIGN_CHECK_EN
        chk("t6_flag", fetch_misaligned, 1'b1);
        chk("t6_req", imem_req, 1'b0);
        chk("t6_valid", instr_valid, 1'b0);
        repeat (3) @(negedge clk);
        chk("t6_flag_sticky", fetch_misaligned, 1'b1);
        chk("t6_req_idle", imem_req, 1'b0);
        do_redirect(32'h200);
        chk("t6_flag_clear", fetch_misaligned, 1'b0);
        wait_next_grant("t6_recover_addr", 32'h200);
`else
        wait_next_grant("t6_forced_align", 32'h100);
`endif

        // PC wrap at the top of the address space.
        do_redirect(32'hFFFF_FFFC);
        wait_valid("wrap_wait");
        chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", Instr, 32'h0003_FFFC);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        wait_next_grant("wrap_addr", 32'h0);

        // Reset during an outstanding fetch; the stale response lands after release and is ignored.
        rv_delay = 3;
        do_redirect(32'h60);
        wait_next_grant("rm_gnt60", 32'h60);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rm_req", imem_req, 1'b0);
        chk("rm_addr", imem_addr, 32'h0);
        chk("rm_valid", instr_valid, 1'b0);
        chk("rm_instr", Instr, NOP);
        chk("rm_ipc", instr_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rv_delay = 1;
        wait_next_grant("rm_first_addr", 32'h0);
        wait_valid("rm_wait");
        chk("rm_after_instr", Instr, 32'hFFFF_0000);
        chk("rm_after_ipc", instr_pc, 32'h0);

        repeat (4) @(negedge clk);
        chk("no_dead_data", seen_dead, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
